// File: rtl/snd_bus_sched_if.sv
// Signal bundle between the host port decoder, the sound-chip bus scheduler and the bus pins.
interface snd_bus_sched_if;
  logic       acc_valid;
  logic [1:0] acc_tgt;
  logic       acc_wr;
  logic       acc_a0;
  logic [7:0] acc_wdata;
  logic [7:0] bus_din;
  logic [7:0] bus_dout;
  logic       bus_doe;
  logic       bus_a0;
  logic [2:0] bus_cs_n;
  logic       bus_rd_n;
  logic       bus_wr_n;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       wait_req;
  logic       busy;
  logic       err;

  modport slave (
    input  acc_valid, acc_tgt, acc_wr, acc_a0, acc_wdata, bus_din,
    output bus_dout, bus_doe, bus_a0, bus_cs_n, bus_rd_n, bus_wr_n,
    output rd_data, rd_valid, wait_req, busy, err
  );

  modport master (
    output acc_valid, acc_tgt, acc_wr, acc_a0, acc_wdata, bus_din,
    input  bus_dout, bus_doe, bus_a0, bus_cs_n, bus_rd_n, bus_wr_n,
    input  rd_data, rd_valid, wait_req, busy, err
  );
endinterface

// File: rtl/snd_bus_sched.sv
// Turns decoded host accesses into timed CS/strobe sequences on the shared YM2203/SAA1099 bus,
// holding the Z80 in wait while the addressed chip is still recovering from its last write.
module snd_bus_sched #(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1,
  parameter int YM_AREC    = 17,
  parameter int YM_DREC    = 83,
  parameter int SAA_REC    = 2,
  parameter int REC_W      = 7
) (
  input  logic           clkcpu,
  input  logic           rst_n,
  snd_bus_sched_if.slave sched_if
);

  typedef enum logic [2:0] {
    IDLE,
    WAITREC,
    SETUP,
    STROBE,
    HOLD
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       phase_q, phase_d;
  logic [1:0]       tgt_q, tgt_d;
  logic             wr_q, wr_d;
  logic             a0_q, a0_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [REC_W-1:0] rec_q [3];

  logic [2:0]       csN_q, csN_d;
  logic             rdN_q, rdN_d;
  logic             wrN_q, wrN_d;
  logic             doe_q, doe_d;
  logic [7:0]       dout_q, dout_d;
  logic             busA0_q, busA0_d;
  logic             waitState_q, waitState_d;
  logic             busy_q, busy_d;
  logic [7:0]       rdData_q;
  logic             rdValid_q;
  logic             err_q;

  logic             accAccept, accReject;
  logic             setupDone, strobeDone, holdDone;
  logic             rdCapture, recLoad, inXfer;
  logic [REC_W-1:0] recAcc, recCur, recLoadVal;

  assign setupDone  = (phase_q == 3'(SETUP_CYC - 1));
  assign strobeDone = (phase_q == 3'(STROBE_CYC - 1));
  assign holdDone   = (phase_q == 3'(HOLD_CYC - 1));

  // Remaining recovery of the chip being requested now and of the latched target.
  always_comb begin
    recAcc = rec_q[2];
    recCur = rec_q[2];
    case (sched_if.acc_tgt)
      2'd0:    recAcc = rec_q[0];
      2'd1:    recAcc = rec_q[1];
      default: recAcc = rec_q[2];
    endcase
    case (tgt_q)
      2'd0:    recCur = rec_q[0];
      2'd1:    recCur = rec_q[1];
      default: recCur = rec_q[2];
    endcase
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    tgt_d     = tgt_q;
    wr_d      = wr_q;
    a0_d      = a0_q;
    wdata_d   = wdata_q;
    accAccept = 1'b0;
    accReject = 1'b0;
    case (state_q)
      IDLE: begin
        if (sched_if.acc_valid) begin
          if (sched_if.acc_tgt == 2'd3 || (sched_if.acc_tgt == 2'd2 && !sched_if.acc_wr)) begin
            accReject = 1'b1;
          end else begin
            accAccept = 1'b1;
            tgt_d     = sched_if.acc_tgt;
            wr_d      = sched_if.acc_wr;
            a0_d      = sched_if.acc_a0;
            wdata_d   = sched_if.acc_wdata;
            phase_d   = '0;
            state_d   = (recAcc == '0) ? SETUP : WAITREC;
          end
        end
      end
      WAITREC: begin
        if (recCur == '0) begin
          state_d = SETUP;
          phase_d = '0;
        end
      end
      SETUP: begin
        phase_d = setupDone ? 3'd0 : phase_q + 3'd1;
        if (setupDone) state_d = STROBE;
      end
      STROBE: begin
        phase_d = strobeDone ? 3'd0 : phase_q + 3'd1;
        if (strobeDone) state_d = HOLD;
      end
      HOLD: begin
        phase_d = holdDone ? 3'd0 : phase_q + 3'd1;
        if (holdDone) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (sched_if.acc_valid && state_q != IDLE) accReject = 1'b1;
  end

  // Bus pins are registered, so they are decoded from the state the FSM is about to enter.
  always_comb begin
    inXfer = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);
    csN_d  = 3'b111;
    if (inXfer) begin
      case (tgt_d)
        2'd0:    csN_d = 3'b110;
        2'd1:    csN_d = 3'b101;
        default: csN_d = 3'b011;
      endcase
    end
    rdN_d       = !(state_d == STROBE && !wr_d);
    wrN_d       = !(state_d == STROBE && wr_d);
    doe_d       = inXfer && wr_d;
    dout_d      = doe_d ? wdata_d : 8'h00;
    busA0_d     = inXfer && a0_d;
    waitState_d = (state_d == WAITREC) || (state_d == SETUP) || (state_d == STROBE);
    busy_d      = (state_d != IDLE);
  end

  assign rdCapture  = (state_q == STROBE) && strobeDone && !wr_q;
  assign recLoad    = (state_q == HOLD) && holdDone && wr_q;
  assign recLoadVal = (tgt_q == 2'd2) ? REC_W'(SAA_REC) :
                      (a0_q ? REC_W'(YM_DREC) : REC_W'(YM_AREC));

  always_ff @(posedge clkcpu or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      tgt_q       <= '0;
      wr_q        <= 1'b0;
      a0_q        <= 1'b0;
      wdata_q     <= '0;
      csN_q       <= 3'b111;
      rdN_q       <= 1'b1;
      wrN_q       <= 1'b1;
      doe_q       <= 1'b0;
      dout_q      <= '0;
      busA0_q     <= 1'b0;
      waitState_q <= 1'b0;
      busy_q      <= 1'b0;
      rdData_q    <= '0;
      rdValid_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      tgt_q       <= tgt_d;
      wr_q        <= wr_d;
      a0_q        <= a0_d;
      wdata_q     <= wdata_d;
      csN_q       <= csN_d;
      rdN_q       <= rdN_d;
      wrN_q       <= wrN_d;
      doe_q       <= doe_d;
      dout_q      <= dout_d;
      busA0_q     <= busA0_d;
      waitState_q <= waitState_d;
      busy_q      <= busy_d;
      rdValid_q   <= rdCapture;
      if (rdCapture) rdData_q <= sched_if.bus_din;
      if (accReject) err_q <= 1'b1;
    end
  end

  // A load on the final HOLD cycle of a write takes priority over that cycle's decrement.
  always_ff @(posedge clkcpu or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) rec_q[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (recLoad && tgt_q == 2'(i)) begin
          rec_q[i] <= recLoadVal;
        end else if (rec_q[i] != '0) begin
          rec_q[i] <= rec_q[i] - REC_W'(1);
        end
      end
    end
  end

  assign sched_if.bus_dout = dout_q;
  assign sched_if.bus_doe  = doe_q;
  assign sched_if.bus_a0   = busA0_q;
  assign sched_if.bus_cs_n = csN_q;
  assign sched_if.bus_rd_n = rdN_q;
  assign sched_if.bus_wr_n = wrN_q;
  assign sched_if.rd_data  = rdData_q;
  assign sched_if.rd_valid = rdValid_q;
  assign sched_if.wait_req = waitState_q | accAccept;
  assign sched_if.busy     = busy_q;
  assign sched_if.err      = err_q;

endmodule

// File: tb/tb_snd_bus_sched.sv
// Randomized scoreboard bench for snd_bus_sched: a cycle-level model of chip availability predicts
// every bus transaction, read return, wait/busy window and error flag.
module tb_snd_bus_sched;
  localparam int S    = 1;
  localparam int ST   = 2;
  localparam int H    = 1;
  localparam int YMA  = 17;
  localparam int YMD  = 83;
  localparam int SAAR = 2;

  typedef struct {
    int         setup;
    int         tgt;
    bit         wr;
    bit         a0;
    logic [7:0] data;
  } txn_t;

  typedef struct {
    int         cyc;
    logic [7:0] data;
  } rd_t;

  logic clkcpu = 1'b0;
  logic rst_n  = 1'b0;
  int   cyc    = 0;

  snd_bus_sched_if sif ();

  snd_bus_sched #(
    .SETUP_CYC (S),
    .STROBE_CYC(ST),
    .HOLD_CYC  (H),
    .YM_AREC   (YMA),
    .YM_DREC   (YMD),
    .SAA_REC   (SAAR),
    .REC_W     (7)
  ) dut (
    .clkcpu  (clkcpu),
    .rst_n   (rst_n),
    .sched_if(sif)
  );

  always #5 clkcpu = ~clkcpu;

  always @(posedge clkcpu) cyc <= cyc + 1;

  txn_t txnQ[$];
  rd_t  rdQ[$];
  bit   expWait[int];
  bit   expBusy[int];
  int   zeroAt[3];
  int   lastEnd;
  int   errFrom;
  int   nCompared = 0;
  int   nMismatched = 0;

  function automatic logic [7:0] dinAt(input int c);
    return 8'(c * 29 + 7);
  endfunction

  function automatic int recOf(input int tgt, input bit a0);
    if (tgt == 2) return SAAR;
    return a0 ? YMD : YMA;
  endfunction

  // bus_din changes every cycle so each read has a distinct, predictable value
  always @(posedge clkcpu) begin
    #1;
    sif.bus_din = dinAt(cyc);
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    nCompared++;
    if (act != exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic resetModel();
    txnQ.delete();
    rdQ.delete();
    expWait.delete();
    expBusy.delete();
    for (int i = 0; i < 3; i++) zeroAt[i] = 0;
    lastEnd = -1;
    errFrom = 32'h7fffffff;
  endtask

  // Model: a chip is usable from the cycle its recovery reads zero; a new access starts
  // SETUP the cycle after max(accept cycle, that cycle).
  task automatic applyStimulus(input int tgt, input bit wr, input bit a0,
                               input logic [7:0] data, output int setupCyc);
    int   c;
    int   st;
    int   hs;
    int   en;
    txn_t t;
    rd_t  r;
    c = cyc;
    setupCyc = -1;
    if (c <= lastEnd || tgt == 3 || (tgt == 2 && !wr)) begin
      if (errFrom > c + 1) errFrom = c + 1;
    end else begin
      st = ((c > zeroAt[tgt]) ? c : zeroAt[tgt]) + 1;
      hs = st + S + ST;
      en = hs + H - 1;
      for (int k = c; k < hs; k++) expWait[k] = 1'b1;
      for (int k = c + 1; k <= en; k++) expBusy[k] = 1'b1;
      lastEnd = en;
      t.setup = st;
      t.tgt   = tgt;
      t.wr    = wr;
      t.a0    = a0;
      t.data  = data;
      txnQ.push_back(t);
      if (wr) begin
        zeroAt[tgt] = en + 1 + recOf(tgt, a0);
      end else begin
        r.cyc  = hs;
        r.data = dinAt(hs - 1);
        rdQ.push_back(r);
      end
      setupCyc = st;
    end
    sif.acc_valid = 1'b1;
    sif.acc_tgt   = 2'(tgt);
    sif.acc_wr    = wr;
    sif.acc_a0    = a0;
    sif.acc_wdata = data;
    @(posedge clkcpu);
    #1;
    sif.acc_valid = 1'b0;
  endtask

  task automatic waitIdle();
    while (cyc <= lastEnd) begin
      @(posedge clkcpu);
      #1;
    end
  endtask

  // Monitor state for the transaction currently visible on the bus
  bit         mActive = 1'b0;
  bit         mBad;
  bit         mRd;
  bit         mWr;
  bit         mPrevStr;
  int         mStart;
  int         mLen;
  int         mStrFirst;
  int         mStrCnt;
  logic [2:0] mCs;
  logic       mA0;
  logic       mDoe;
  logic [7:0] mDout;

  task automatic finishTxn();
    txn_t       t;
    logic [2:0] expCs;
    checkOutput("txn_expected", int'(txnQ.size() > 0), 1);
    if (txnQ.size() > 0) begin
      t = txnQ.pop_front();
      expCs = 3'b111;
      expCs[t.tgt] = 1'b0;
      checkOutput("txn_start", mStart, t.setup);
      checkOutput("txn_cs_n", int'(mCs), int'(expCs));
      checkOutput("txn_len", mLen, S + ST + H);
      checkOutput("strobe_offset", mStrFirst, S);
      checkOutput("strobe_len", mStrCnt, ST);
      checkOutput("strobe_kind", int'({mRd, mWr}), int'({!t.wr, t.wr}));
      checkOutput("txn_a0", int'(mA0), int'(t.a0));
      checkOutput("txn_doe", int'(mDoe), int'(t.wr));
      checkOutput("txn_dout", int'(mDout), t.wr ? int'(t.data) : 0);
      checkOutput("txn_stable", int'(mBad), 0);
    end
  endtask

  always @(negedge clkcpu) begin
    if (!rst_n) begin
      mActive = 1'b0;
    end else begin
      checkOutput("wait_req", int'(sif.wait_req), int'(expWait.exists(cyc)));
      checkOutput("busy", int'(sif.busy), int'(expBusy.exists(cyc)));
      checkOutput("err", int'(sif.err), int'(cyc >= errFrom));
      if (sif.bus_cs_n != 3'b111) begin
        if (!mActive) begin
          mActive   = 1'b1;
          mStart    = cyc;
          mCs       = sif.bus_cs_n;
          mA0       = sif.bus_a0;
          mDoe      = sif.bus_doe;
          mDout     = sif.bus_dout;
          mLen      = 0;
          mStrFirst = -1;
          mStrCnt   = 0;
          mRd       = 1'b0;
          mWr       = 1'b0;
          mBad      = 1'b0;
          mPrevStr  = 1'b0;
        end else if (sif.bus_cs_n != mCs || sif.bus_a0 != mA0 ||
                     sif.bus_doe != mDoe || sif.bus_dout != mDout) begin
          mBad = 1'b1;
        end
        if (!sif.bus_rd_n || !sif.bus_wr_n) begin
          if (mStrFirst < 0) mStrFirst = mLen;
          else if (!mPrevStr) mBad = 1'b1;
          mStrCnt++;
          if (!sif.bus_rd_n) mRd = 1'b1;
          if (!sif.bus_wr_n) mWr = 1'b1;
          mPrevStr = 1'b1;
        end else begin
          mPrevStr = 1'b0;
        end
        mLen++;
      end else begin
        checkOutput("idle_bus", int'({sif.bus_rd_n, sif.bus_wr_n, sif.bus_doe, sif.bus_a0}), 12);
        if (mActive) begin
          mActive = 1'b0;
          finishTxn();
        end
      end
      if (sif.rd_valid) begin
        checkOutput("rd_expected", int'(rdQ.size() > 0), 1);
        if (rdQ.size() > 0) begin
          checkOutput("rd_valid_cycle", cyc, rdQ[0].cyc);
          checkOutput("rd_data", int'(sif.rd_data), int'(rdQ[0].data));
          void'(rdQ.pop_front());
        end
      end
    end
  end

  initial begin
    int s;
    int pick;
    int tgt;
    resetModel();
    sif.acc_valid = 1'b0;
    sif.acc_tgt   = 2'd0;
    sif.acc_wr    = 1'b0;
    sif.acc_a0    = 1'b0;
    sif.acc_wdata = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(posedge clkcpu);
    #1;
    checkOutput("reset_cs_n", int'(sif.bus_cs_n), 7);
    checkOutput("reset_strobes", int'({sif.bus_rd_n, sif.bus_wr_n}), 3);
    checkOutput("reset_doe_a0", int'({sif.bus_doe, sif.bus_a0}), 0);
    checkOutput("reset_dout", int'(sif.bus_dout), 0);
    checkOutput("reset_rd", int'({sif.rd_data, sif.rd_valid}), 0);
    checkOutput("reset_status", int'({sif.wait_req, sif.busy, sif.err}), 0);
    rst_n = 1'b1;
    @(posedge clkcpu);
    #1;

    // YM1 address write, then a data write on the first idle cycle (must sit out 17 cycles)
    applyStimulus(0, 1'b1, 1'b0, 8'h27, s);
    waitIdle();
    applyStimulus(0, 1'b1, 1'b1, 8'h55, s);
    waitIdle();
    applyStimulus(1, 1'b1, 1'b0, 8'h0E, s);
    waitIdle();
    applyStimulus(1, 1'b0, 1'b0, 8'h00, s);
    waitIdle();
    applyStimulus(2, 1'b0, 1'b0, 8'h00, s);
    applyStimulus(3, 1'b1, 1'b0, 8'hFF, s);
    applyStimulus(2, 1'b1, 1'b1, 8'h3C, s);
    applyStimulus(1, 1'b1, 1'b1, 8'h99, s);
    waitIdle();

    // Abort a YM2 write mid-strobe right after YM1 loaded its long recovery
    applyStimulus(0, 1'b1, 1'b1, 8'hA5, s);
    waitIdle();
    applyStimulus(1, 1'b1, 1'b0, 8'h42, s);
    while (cyc < s + S) begin
      @(posedge clkcpu);
      #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_cs_n", int'(sif.bus_cs_n), 7);
    checkOutput("abort_strobes", int'({sif.bus_rd_n, sif.bus_wr_n}), 3);
    checkOutput("abort_busy", int'(sif.busy), 0);
    checkOutput("abort_wait", int'(sif.wait_req), 0);
    @(posedge clkcpu);
    #1;
    resetModel();
    rst_n = 1'b1;
    applyStimulus(0, 1'b1, 1'b1, 8'h11, s);
    waitIdle();

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        waitIdle();
      end else begin
        repeat ($urandom_range(0, 20)) begin
          @(posedge clkcpu);
          #1;
        end
      end
      pick = int'($urandom_range(0, 9));
      tgt  = (pick < 4) ? 0 : (pick < 8) ? 1 : (pick == 8) ? 2 : 3;
      applyStimulus(tgt, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), s);
    end

    waitIdle();
    repeat (4) @(posedge clkcpu);
    #1;
    checkOutput("txn_drained", txnQ.size(), 0);
    checkOutput("rd_drained", rdQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
